in_collect: RTL and testbench
=============================

IN_COLLECT -- requirements
Module: in_collect

Interface
REQ-001 Parameter WORDS_PER_RND, default 8, 128-bit words per round before handoff.
REQ-002 Parameter OUT_CYC, default 2, cycles held in OUT state per round.
REQ-003 Parameter TOTAL_WORDS, default 48, words per run; must be a multiple of WORDS_PER_RND and at most 63.
REQ-004 clk  input  1  sole clock; all logic on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 iot_in  input  8  input data byte.
REQ-007 in_en  input  1  iot_in is valid this cycle.
REQ-008 busy  output  1  high: the block accepts no bytes.
REQ-009 data  output  128  last fully assembled word.
REQ-010 data_vld  output  1  one-cycle pulse: data holds a new word.
REQ-011 cycle_cnt  output  8  bytes accepted in the current round, 0..WORDS_PER_RND*16-1.
REQ-012 cnt  output  6  words completed in the run.
REQ-013 state  output  3  current FSM state code.
REQ-014 err  output  1  sticky protocol error (see Configuration).

Function
REQ-015 FSM encodings: IDLE=3'b000, LOAD=3'b001, OUT=3'b010, DONE=3'b011; codes 100-111 are unused and go to IDLE.
REQ-016 A byte is accepted at a rising edge iff in_en=1, busy=0 and state is IDLE or LOAD.
REQ-017 IDLE goes to LOAD on the first accepted byte; that byte is stored.
REQ-018 Byte order: the first accepted byte of a word fills bits [127:120], the 16th fills [7:0]; packing is MSB-first.
REQ-019 A byte-in-word counter (0..15) increments per accepted byte and holds during in_en gaps; a partial word is retained.
REQ-020 On the edge accepting byte 16: data is loaded with the full word, data_vld=1 for exactly the next cycle, cnt+1, byte counter wraps to 0.
REQ-021 cycle_cnt increments per accepted byte and wraps to 0 at round completion.
REQ-022 When the completed word is word WORDS_PER_RND of a round: on the same edge, go to OUT and set busy=1 (visible together with data_vld).
REQ-023 OUT lasts exactly OUT_CYC cycles, then goes to LOAD with busy=0; if cnt==TOTAL_WORDS it goes to DONE instead.
REQ-024 DONE holds busy=1 and all counters frozen until reset.
REQ-025 Bytes presented while busy=1 are dropped: no counter or data change.
REQ-026 busy=0 in IDLE and LOAD, and 1 in OUT and DONE.
REQ-027 data holds its value between words; data_vld is never high two consecutive cycles.

Reset
REQ-028 With rst=0 at an edge, the block returns to IDLE, including mid-word and mid-OUT.
REQ-029 Reset values: busy=0, data=0, data_vld=0, cycle_cnt=0, cnt=0, state=3'b000, err=0, partial word discarded.

Configuration
REQ-030 Macro IN_COLLECT_ERR_EN defined: err is set to 1 on any edge where in_en=1 and busy=1, and stays set until reset.
REQ-031 IN_COLLECT_ERR_EN undefined: the err port exists and is constant 0, with no detection logic.

Structure
REQ-032 Shared package iot_pkg holds the state encodings, WORD_W=128 and BYTE_W=8, so they are shared with the output stage.
REQ-033 One sub-module, in_shift16, holds the byte shift register and the 0..15 counter and returns the word-done strobe; the FSM and counters stay in in_collect.

Verification
REQ-034 Reset, then 16 bytes 0x00..0x0F with in_en steady -> data_vld one cycle after byte 16; data=0x000102...0F; cnt=1; state=LOAD.
REQ-035 Same 16 bytes with in_en low every other cycle -> identical data; data_vld asserts once.
REQ-036 128 consecutive bytes -> 8 data_vld pulses; busy=1 and state=010 for 2 cycles, then state=001 and busy=0; cycle_cnt=0.
REQ-037 In_en held high during OUT with byte 0xAA -> 0xAA not captured; err=1 with the macro and 0 without.
REQ-038 768 bytes -> cnt=48, state=011, busy stays 1; further bytes are ignored.
REQ-039 rst=0 after byte 9 of a word -> the next cycle shows all reset values; a fresh 16 bytes produce a clean word.

Source files
------------

// File: rtl/iot_pkg.sv
// Shared definitions for the IoT input collector and its output stage.
package iot_pkg;

  localparam int unsigned WORD_W         = 128;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned BYTES_PER_WORD = WORD_W / BYTE_W;
  localparam int unsigned STATE_W        = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 3'b000,
    ST_LOAD = 3'b001,
    ST_OUT  = 3'b010,
    ST_DONE = 3'b011
  } state_e;

endpackage

// File: rtl/in_shift16.sv
// MSB-first byte shift register with a 0..15 byte-in-word counter.
// Returns the assembled word and its completion strobe combinationally.
module in_shift16
  import iot_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_en_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [WORD_W-1:0] word_c_o,
  output logic              word_done_c_o
);

  localparam int unsigned SR_W  = WORD_W - BYTE_W;
  localparam int unsigned CNT_W = $clog2(BYTES_PER_WORD);

  logic [SR_W-1:0]  sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The 16th byte completes the word in the same cycle it is presented.
  assign word_c_o      = {sr_q, byte_i};
  assign word_done_c_o = shift_en_i && (cnt_q == CNT_W'(BYTES_PER_WORD - 1));

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (shift_en_i) begin
      sr_d  = word_c_o[SR_W-1:0];
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/in_collect.sv
// Byte-to-128-bit word collector with round handoff (OUT) and end-of-run DONE.
// Optional macro IN_COLLECT_ERR_EN enables sticky detection of bytes sent while busy.
module in_collect
  import iot_pkg::*;
#(
  parameter int unsigned WORDS_PER_RND = 8,
  parameter int unsigned OUT_CYC       = 2,
  parameter int unsigned TOTAL_WORDS   = 48
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BYTE_W-1:0]  iot_in,
  input  logic               in_en,
  output logic               busy,
  output logic [WORD_W-1:0]  data,
  output logic               data_vld,
  output logic [7:0]         cycle_cnt,
  output logic [5:0]         cnt,
  output logic [STATE_W-1:0] state,
  output logic               err
);

  localparam int unsigned CYC_W    = 8;
  localparam int unsigned CNT_W    = 6;
  localparam int unsigned OUT_W    = (OUT_CYC > 1) ? $clog2(OUT_CYC) : 1;
  localparam int unsigned RND_LAST = WORDS_PER_RND * BYTES_PER_WORD - 1;

  state_e             state_q, state_d;
  logic               busy_q, busy_d;
  logic [WORD_W-1:0]  data_q, data_d;
  logic               vld_q, vld_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0]   out_q, out_d;

  logic               accept_c;
  logic               word_done_c;
  logic [WORD_W-1:0]  word_c;

  assign accept_c = in_en && !busy_q && ((state_q == ST_IDLE) || (state_q == ST_LOAD));

  in_shift16 u_shift (
    .clk           (clk),
    .rst           (rst),
    .shift_en_i    (accept_c),
    .byte_i        (iot_in),
    .word_c_o      (word_c),
    .word_done_c_o (word_done_c)
  );

  // Next-state, counters and handoff control.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    vld_d   = 1'b0;
    cyc_d   = cyc_q;
    cnt_d   = cnt_q;
    out_d   = out_q;

    case (state_q)
      ST_IDLE: if (accept_c) state_d = ST_LOAD;
      ST_LOAD: ;
      ST_OUT: begin
        if (out_q == OUT_W'(OUT_CYC - 1)) begin
          state_d = (cnt_q == CNT_W'(TOTAL_WORDS)) ? ST_DONE : ST_LOAD;
        end else begin
          out_d = out_q + OUT_W'(1);
        end
      end
      ST_DONE: ;
      default: state_d = ST_IDLE;
    endcase

    if (accept_c) begin
      cyc_d = cyc_q + CYC_W'(1);
      if (word_done_c) begin
        data_d = word_c;
        vld_d  = 1'b1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cyc_q == CYC_W'(RND_LAST)) begin
          cyc_d   = '0;
          out_d   = '0;
          state_d = ST_OUT;
        end
      end
    end

    busy_d = (state_d == ST_OUT) || (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      cyc_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      cyc_q   <= cyc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

`ifdef IN_COLLECT_ERR_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (in_en && busy_q) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign busy      = busy_q;
  assign data      = data_q;
  assign data_vld  = vld_q;
  assign cycle_cnt = cyc_q;
  assign cnt       = cnt_q;
  assign state     = state_q;

endmodule

// File: tb/tb_in_collect.sv
// Directed self-checking bench for in_collect (default parameters).
module tb_in_collect;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   iot_in;
  logic         in_en;
  logic         busy;
  logic [127:0] data;
  logic         data_vld;
  logic [7:0]   cycle_cnt;
  logic [5:0]   cnt;
  logic [2:0]   state;
  logic         err;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses;
  logic [127:0] exp_w;

`ifdef IN_COLLECT_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  in_collect dut (
    .clk       (clk),
    .rst       (rst),
    .iot_in    (iot_in),
    .in_en     (in_en),
    .busy      (busy),
    .data      (data),
    .data_vld  (data_vld),
    .cycle_cnt (cycle_cnt),
    .cnt       (cnt),
    .state     (state),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b0;
    in_en = 1'b0;
    step();
    rst = 1'b1;
  endtask

  // Wait (bounded) for busy to drop, then present one byte for one cycle.
  task automatic send(input logic [7:0] b);
    int budget;
    budget = 0;
    while (busy && budget < 32) begin
      in_en = 1'b0;
      step();
      budget++;
    end
    if (busy) check("busy_timeout", busy, 0);
    iot_in = b;
    in_en  = 1'b1;
    step();
    if (data_vld) pulses++;
  endtask

  function automatic logic [127:0] mkword(input logic [7:0] first);
    logic [127:0] w;
    w = '0;
    for (int i = 0; i < 16; i++) w = {w[119:0], first + 8'(i)};
    return w;
  endfunction

  initial begin
    rst    = 1'b1;
    iot_in = 8'h00;
    in_en  = 1'b0;

    // Reset values
    do_reset();
    check("rst_busy", busy, 0);
    check("rst_data", data, 0);
    check("rst_vld", data_vld, 0);
    check("rst_cyc", cycle_cnt, 0);
    check("rst_cnt", cnt, 0);
    check("rst_state", state, 0);
    check("rst_err", err, 0);

    // 16 bytes with in_en steady
    pulses = 0;
    for (int i = 0; i < 15; i++) send(8'(i));
    check("w1_no_early_vld", data_vld, 0);
    check("w1_state_load", state, 3'b001);
    send(8'h0F);
    in_en = 1'b0;
    check("w1_vld", data_vld, 1);
    check("w1_data", data, 128'h000102030405060708090A0B0C0D0E0F);
    check("w1_cnt", cnt, 1);
    check("w1_state", state, 3'b001);
    check("w1_cyc", cycle_cnt, 16);
    step();
    check("w1_vld_drop", data_vld, 0);
    check("w1_data_hold", data, 128'h000102030405060708090A0B0C0D0E0F);

    // Same bytes with in_en low every other cycle
    do_reset();
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      send(8'(i));
      in_en  = 1'b0;
      iot_in = 8'hEE;
      step();
      if (data_vld) pulses++;
    end
    check("gap_data", data, 128'h000102030405060708090A0B0C0D0E0F);
    check("gap_pulses", pulses, 1);
    check("gap_cnt", cnt, 1);

    // One full round of 128 bytes, then 0xAA pushed during OUT
    do_reset();
    pulses = 0;
    for (int i = 0; i < 128; i++) send(8'(i));
    check("rnd_pulses", pulses, 8);
    check("rnd_vld", data_vld, 1);
    check("rnd_state_out", state, 3'b010);
    check("rnd_busy", busy, 1);
    check("rnd_cyc", cycle_cnt, 0);
    check("rnd_cnt", cnt, 8);
    exp_w = mkword(8'h70);
    check("rnd_data", data, exp_w);
    iot_in = 8'hAA;
    in_en  = 1'b1;
    step();
    check("out1_state", state, 3'b010);
    check("out1_busy", busy, 1);
    check("out1_vld", data_vld, 0);
    check("out1_err", err, ERR_EXP);
    step();
    in_en = 1'b0;
    check("out2_state_load", state, 3'b001);
    check("out2_busy", busy, 0);
    check("out2_cyc", cycle_cnt, 0);
    check("out2_cnt", cnt, 8);
    check("out2_data", data, exp_w);
    for (int i = 0; i < 16; i++) send(8'h10 + 8'(i));
    in_en = 1'b0;
    check("post_out_data", data, mkword(8'h10));
    check("post_out_cnt", cnt, 9);
    check("post_out_cyc", cycle_cnt, 16);
    check("post_out_err", err, ERR_EXP);

    // Full run of 768 bytes into DONE
    do_reset();
    for (int k = 0; k < 768; k++) send(8'(k));
    in_en = 1'b0;
    exp_w = mkword(8'hF0);
    check("run_cnt", cnt, 48);
    check("run_state_out", state, 3'b010);
    check("run_data", data, exp_w);
    check("run_err_clean", err, 0);
    step();
    step();
    check("done_state", state, 3'b011);
    check("done_busy", busy, 1);
    iot_in = 8'h55;
    in_en  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (data_vld) pulses++;
    end
    in_en = 1'b0;
    check("done_cnt_frozen", cnt, 48);
    check("done_cyc_frozen", cycle_cnt, 0);
    check("done_data_frozen", data, exp_w);
    check("done_no_vld", pulses, 0);
    check("done_state_hold", state, 3'b011);
    check("done_busy_hold", busy, 1);
    check("done_err", err, ERR_EXP);

    // Reset after byte 9 of a word, then a clean word
    do_reset();
    for (int i = 0; i < 9; i++) send(8'h30 + 8'(i));
    check("mid_state", state, 3'b001);
    check("mid_cyc", cycle_cnt, 9);
    rst    = 1'b0;
    in_en  = 1'b1;
    iot_in = 8'h77;
    step();
    in_en = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_data", data, 0);
    check("mid_rst_vld", data_vld, 0);
    check("mid_rst_cyc", cycle_cnt, 0);
    check("mid_rst_cnt", cnt, 0);
    check("mid_rst_state", state, 0);
    check("mid_rst_err", err, 0);
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 16; i++) send(8'hA0 + 8'(i));
    in_en = 1'b0;
    check("fresh_data", data, mkword(8'hA0));
    check("fresh_vld", data_vld, 1);
    check("fresh_pulses", pulses, 1);
    check("fresh_cnt", cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
